// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_update_unit
// Description : Program counter, branch resolution, carry flag and retire count
// Revision    : 1.0
// ============================================================================
module pc_update_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [2:0]  CondJump,
    input  logic        UncondJump,
    input  logic [1:0]  AddrSel,
    input  logic        halt,
    input  logic        flag_we,
    input  logic        alu_carry,
    input  logic [31:0] rs_data,
    input  logic [25:0] imm26,
    input  logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        branch_taken,
    output logic        carry_q,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [2:0] c_cj_bltz = 3'b001;
    localparam logic [2:0] c_cj_bz   = 3'b010;
    localparam logic [2:0] c_cj_bnz  = 3'b011;
    localparam logic [2:0] c_cj_bcy  = 3'b100;
    localparam logic [2:0] c_cj_bncy = 3'b101;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_carry;
    logic [31:0] r_retired;

    logic        w_cond_met;
    logic        w_commit;
    logic [31:0] w_offset;
    logic [31:0] w_target;

    assign w_commit = (r_state == ST_RUN) && instr_valid;
    assign pc_plus4 = r_pc + 32'd4;

    // Carry conditions look at the registered flag, never this cycle's ALU carry.
    always_comb begin
        w_cond_met = 1'b0;
        case (CondJump)
            c_cj_bltz: w_cond_met = rs_data[31];
            c_cj_bz:   w_cond_met = (rs_data == 32'd0);
            c_cj_bnz:  w_cond_met = (rs_data != 32'd0);
            c_cj_bcy:  w_cond_met = r_carry;
            c_cj_bncy: w_cond_met = ~r_carry;
            default:   w_cond_met = 1'b0;
        endcase
    end

    assign branch_taken = w_commit && (UncondJump || w_cond_met);

    always_comb begin
        w_offset = {{4{imm26[25]}}, imm26, 2'b00};
        w_target = pc_plus4 + w_offset;
        if (AddrSel == 2'b10) begin
            w_offset = {{14{imm16[15]}}, imm16, 2'b00};
            w_target = pc_plus4 + w_offset;
        end else if (AddrSel == 2'b01) begin
            w_target = {rs_data[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_pc      <= 32'd0;
            r_carry   <= 1'b0;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (instr_valid) begin
                        r_retired <= r_retired + 32'd1;
                        if (halt) begin
                            // pc stays on the halt instruction
                            r_state <= ST_HALT;
                        end else begin
                            r_pc <= branch_taken ? w_target : pc_plus4;
                            if (flag_we) begin
                                r_carry <= alu_carry;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign carry_q = r_carry;
    assign retired = r_retired;
    assign halted  = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_update_unit
// Description : Self-checking bench for pc_update_unit with reference model
// Revision    : 1.0
// ============================================================================
module tb_pc_update_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [2:0]  CondJump;
    logic        UncondJump;
    logic [1:0]  AddrSel;
    logic        halt;
    logic        flag_we;
    logic        alu_carry;
    logic [31:0] rs_data;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        carry_q;
    logic        halted;
    logic [31:0] retired;

    pc_update_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .CondJump     (CondJump),
        .UncondJump   (UncondJump),
        .AddrSel      (AddrSel),
        .halt         (halt),
        .flag_we      (flag_we),
        .alu_carry    (alu_carry),
        .rs_data      (rs_data),
        .imm26        (imm26),
        .imm16        (imm16),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .carry_q      (carry_q),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_carry;
    logic        m_halted;
    logic [31:0] m_retired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken();
        logic cond;
        if (m_halted || !instr_valid) return 1'b0;
        case (CondJump)
            3'd1:    cond = rs_data[31];
            3'd2:    cond = (rs_data == 0);
            3'd3:    cond = (rs_data != 0);
            3'd4:    cond = m_carry;
            3'd5:    cond = !m_carry;
            default: cond = 1'b0;
        endcase
        return UncondJump || cond;
    endfunction

    function automatic logic [31:0] model_target();
        longint off;
        if (AddrSel == 2'b01) return rs_data & 32'hFFFF_FFFC;
        if (AddrSel == 2'b10) off = longint'($signed(imm16));
        else                  off = longint'($signed(imm26));
        return 32'(longint'(m_pc) + 4 + off * 4);
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".carry"}, 32'(carry_q), 32'(m_carry));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
        chk({tag, ".retired"}, retired, m_retired);
    endtask

    // Called just after a falling edge: drive one instruction, check, clock it in.
    task automatic commit(input logic iv, input logic [2:0] cj, input logic uj,
                          input logic [1:0] as, input logic h, input logic fw,
                          input logic ac, input logic [31:0] rs,
                          input logic [25:0] i26, input logic [15:0] i16);
        logic        e_taken;
        logic [31:0] e_target;
        instr_valid = iv; CondJump = cj; UncondJump = uj; AddrSel = as;
        halt = h; flag_we = fw; alu_carry = ac; rs_data = rs; imm26 = i26; imm16 = i16;
        #1;
        e_taken  = model_taken();
        e_target = model_target();
        chk("branch_taken", 32'(branch_taken), 32'(e_taken));
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        @(posedge clk);
        if (!m_halted && iv) begin
            m_retired = m_retired + 1;
            if (h) begin
                m_halted = 1'b1;
            end else begin
                m_pc = e_taken ? e_target : m_pc + 32'd4;
                if (fw) m_carry = ac;
            end
        end
        @(negedge clk);
        check_regs("commit");
    endtask

    task automatic rand_commit(input int halt_odds);
        commit(($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 3) == 0),
               2'($urandom), ($urandom_range(0, halt_odds) == 0), 1'($urandom),
               1'($urandom), $urandom, 26'($urandom), 16'($urandom));
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        m_pc = 0; m_carry = 0; m_halted = 0; m_retired = 0;
        check_regs("async_rst");
        instr_valid = 1'b1; halt = 1'b0; UncondJump = 1'b1; flag_we = 1'b1;
        alu_carry = 1'b1; rs_data = $urandom;
        @(negedge clk);
        @(negedge clk);
        check_regs("in_rst");
        rst = 1'b1;
    endtask

    task automatic br(input logic [31:0] addr);
        commit(1'b1, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, addr, 26'd0, 16'd0);
    endtask

    task automatic plain();
        commit(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom), 16'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 0; CondJump = 0; UncondJump = 0; AddrSel = 0; halt = 0;
        flag_we = 0; alu_carry = 0; rs_data = 0; imm26 = 0; imm16 = 0;
        m_pc = 0; m_carry = 0; m_halted = 0; m_retired = 0;
        @(negedge clk);
        do_reset();

        // straight-line commits
        plain(); plain(); plain();
        chk("seq.pc", pc, 32'd12);
        chk("seq.retired", retired, 32'd3);

        // long branches
        br(32'h0000_0103);
        chk("br.pc100", pc, 32'h100);
        commit(1'b1, 3'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 26'h3FF_FFFE, 16'd0);
        chk("b.neg", pc, 32'h0FC);
        br(32'h20);
        br(32'h203);
        chk("br.203", pc, 32'h200);

        // conditional branches
        br(32'h20);
        commit(1'b1, 3'd2, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 16'd4);
        chk("bz.taken", pc, 32'h34);
        br(32'h20);
        commit(1'b1, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 16'd4);
        chk("bnz.not", pc, 32'h24);
        br(32'h20);
        commit(1'b1, 3'd1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 26'd0, 16'hFFFF);
        chk("bltz.self", pc, 32'h20);

        // carry flag and bcy/bncy ordering
        commit(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd0, 26'd0, 16'd0);
        chk("flag.set", 32'(carry_q), 32'd1);
        commit(1'b1, 3'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 26'd8, 16'd0);
        chk("bcy.taken", pc, 32'h24 + 32'd4 + 32'h20);
        commit(1'b1, 3'd5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 26'd8, 16'd0);
        chk("bncy.carry", 32'(carry_q), 32'd0);
        chk("bncy.pc", pc, 32'h4C);

        // halt freezes everything until reset
        br(32'h40);
        commit(1'b1, 3'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 32'h80, 26'd0, 16'd0);
        chk("halt.flag", 32'(halted), 32'd1);
        chk("halt.pc", pc, 32'h40);
        for (int i = 0; i < 12; i++) rand_commit(2);
        chk("halt.frozen", pc, 32'h40);
        do_reset();

        // address wrap and stall
        br(32'hFFFF_FFFC);
        plain();
        chk("wrap.pc", pc, 32'd0);
        for (int i = 0; i < 5; i++)
            commit(1'b0, 3'($urandom), 1'b1, 2'($urandom), 1'($urandom), 1'b1,
                   1'b1, $urandom, 26'($urandom), 16'($urandom));
        chk("stall.pc", pc, 32'd0);
        commit(1'b0, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 16'd0);

        // random traffic with occasional halts and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) do_reset();
            else rand_commit(40);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003: instr_valid  input  1  current instruction committed this cycle; no state changes when 0.
REQ-004: CondJump  input  3  branch condition code from control unit: 000 none, 001 bltz, 010 bz, 011 bnz, 100 bcy, 101 bncy, 110/111 never taken.
REQ-005: UncondJump  input  1  unconditional branch (b, bl, br).
REQ-006: AddrSel  input  2  target select: 00 PC+4+sext(imm26)<<2, 01 rs_data, 10 PC+4+sext(imm16)<<2, 11 treated as 00.
REQ-007: halt  input  1  halt instruction decoded.
REQ-008: flag_we  input  1  ALU instruction; write carry flag.
REQ-009: alu_carry  input  1  ALU carry-out of current instruction.
REQ-010: rs_data  input  32  register rs read value.
REQ-011: imm26  input  26  long branch offset, in words.
REQ-012: imm16  input  16  conditional branch offset, in words.
REQ-013: pc  output  32  registered byte address of current instruction.
REQ-014: pc_plus4  output  32  combinational pc+4, mod 2^32; link value for bl.
REQ-015: branch_taken  output  1  combinational; next PC is the target.
REQ-016: carry_q  output  1  registered carry flag.
REQ-017: halted  output  1  registered sticky halt status.
REQ-018: retired  output  32  registered count of committed instructions.

Function
REQ-019: State machine SHALL have two states, RUN and HALT; reset enters RUN; halted = 1 exactly when in HALT.
REQ-020: In RUN with instr_valid=1 and halt=0: pc <= target if branch_taken, else pc_plus4; retired <= retired+1.
REQ-021: branch_taken SHALL be UncondJump OR (cond met): 001 rs_data[31]=1; 010 rs_data=0; 011 rs_data!=0; 100 carry_q=1; 101 carry_q=0; else 0. SHALL be forced 0 in HALT or when instr_valid=0.
REQ-022: UncondJump=1 SHALL take regardless of CondJump.
REQ-023: Target arithmetic: 32-bit, sign-extended offset shifted left 2, added to pc_plus4, wrap mod 2^32. For AddrSel=01, target = {rs_data[31:2],2'b00}.
REQ-024: pc+4 and retired SHALL wrap at 2^32 without error indication.
REQ-025: carry_q <= alu_carry when RUN, instr_valid=1 and flag_we=1; else hold.
REQ-026: bcy/bncy SHALL evaluate the pre-edge carry_q; a same-cycle flag_we write SHALL NOT affect that decision.
REQ-027: In RUN with instr_valid=1 and halt=1: go to HALT; pc holds (points at halt instruction); retired +1; carry_q holds.
REQ-028: halt=1 with instr_valid=0 SHALL have no effect.
REQ-029: In HALT: pc, carry_q, retired frozen; all inputs ignored; exit only via reset.
REQ-030: instr_valid=0 in RUN: all registers hold (stall).

Reset
REQ-031: rst=0 SHALL immediately, independent of clk, force pc=0, carry_q=0, retired=0, state=RUN (halted=0).
REQ-032: Reset asserted mid-operation, including in HALT, SHALL discard pending update; first commit after release uses pc=0.
REQ-033: Outputs SHALL hold reset values while rst=0 regardless of clk or inputs.

Verification
REQ-034: Reset, then 3 commits with no branch -> pc 0,4,8,12; retired=3; branch_taken=0.
REQ-035: pc=0x100, b with imm26=0x3FFFFFE (-2) -> pc=0x0FC; with bl, pc_plus4=0x104 during that cycle.
REQ-036: pc=0x20, br rs_data=0x00000203 -> pc=0x200; bz rs_data=0 imm16=4 -> pc=0x34; bnz rs_data=0 -> pc=0x24; bltz rs_data=0x80000000 imm16=0xFFFF -> pc=0x20.
REQ-037: carry_q=0, instruction with flag_we=1 alu_carry=1 then bcy imm26=8 -> pc = bcy pc+4+0x20; bncy in that cycle with simultaneous flag_we=1 alu_carry=0 and carry_q=1 -> not taken, carry_q becomes 0.
REQ-038: pc=0x40 halt with instr_valid=1 -> halted=1, pc stays 0x40 for 10+ cycles under random inputs; retired frozen; rst pulse low mid-cycle -> pc=0, halted=0 asynchronously.
REQ-039: pc=0xFFFFFFFC, no branch -> pc=0; retired=0xFFFFFFFF plus one commit -> 0; instr_valid=0 for 5 cycles -> no register changes.
